// File: rtl/mips32_mem_arbiter_if.sv
// mips32_mem_arbiter_if: requester and memory-macro bus of the arbiter.
// Ports: IF read channel (if_*), data channel (d_*), memory macro (mem_*), busy.
// Modports: slave = arbiter side, master = requesters/memory side.
interface mips32_mem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          if_rvalid;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          d_rvalid;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output if_ack, if_rdata, if_rvalid,
        output d_ack, d_rdata, d_rvalid,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  if_ack, if_rdata, if_rvalid,
        input  d_ack, d_rdata, d_rvalid,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter: shares the single-port unified memory between IF and MEM.
// Ports: clk, rst (async, active high), bus (mips32_mem_arbiter_if.slave).
// Data port has priority; define MIPS32_ARB_STARVE_GUARD_EN to bound IF lockout
// to STARVE_MAX consecutive losses. All outputs are registered.
module mips32_mem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    mips32_mem_arbiter_if.slave     bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          win_d_q, win_d_d;   // 1: data port owns the transaction
    logic          if_ack_q, if_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic          d_rvalid_q, d_rvalid_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          busy_q, busy_d;

    logic arbitrate;
    logic any_req;
    logic force_if;
    logic pick_data;

    assign arbitrate = (state_q == S_IDLE) || (state_q == S_RESP);
    assign any_req   = bus.d_req || bus.if_req;
    // The guard can only override data when IF is actually asking.
    assign pick_data = bus.d_req && !(force_if && bus.if_req);

`ifdef MIPS32_ARB_STARVE_GUARD_EN
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [SW-1:0] starve_q, starve_d;

    assign force_if = (starve_q == SMAX);

    always_comb begin
        starve_d = starve_q;
        if (arbitrate && any_req) begin
            if (!pick_data) begin
                starve_d = '0;
            end else if (bus.if_req) begin
                starve_d = (starve_q == SMAX) ? SMAX : starve_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_starve_cfg;

    assign force_if          = 1'b0;
    assign unused_starve_cfg = (STARVE_MAX != 0);
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        win_d_d     = win_d_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            S_IDLE, S_RESP: begin
                if (any_req) begin
                    state_d     = S_ISSUE;
                    win_d_d     = pick_data;
                    d_ack_d     = pick_data;
                    if_ack_d    = !pick_data;
                    mem_en_d    = 1'b1;
                    mem_we_d    = pick_data && bus.d_we;
                    mem_addr_d  = pick_data ? bus.d_addr : bus.if_addr;
                    mem_wdata_d = bus.d_wdata;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (mem_we_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = LAT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    if (win_d_q) begin
                        d_rdata_d  = bus.mem_rdata;
                        d_rvalid_d = 1'b1;
                    end else begin
                        if_rdata_d  = bus.mem_rdata;
                        if_rvalid_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            win_d_q     <= 1'b0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            win_d_q     <= win_d_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.if_ack    = if_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// tb_mips32_mem_arbiter: directed bench for mips32_mem_arbiter (MEM_LAT=2).
// Memory model: 2-cycle read pipeline, unwritten words return a fixed pattern.
module tb_mips32_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mips32_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mips32_mem_arbiter #(
        .AW(AW), .DW(DW), .MEM_LAT(2), .STARVE_MAX(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [31:0] init_word(input logic [9:0] a);
        case (a)
            10'h004: init_word = 32'hDEADBEEF;
            10'h005: init_word = 32'hCAFEF00D;
            default: init_word = {16'hA5A5, 6'b0, a};
        endcase
    endfunction

    logic [31:0]   mem [0:1023];
    logic [1023:0] wr_map;
    logic [31:0]   p1, p2;

    always @(posedge clk) begin
        if (rst) begin
            wr_map <= '0;
        end else if (bus.mem_en && bus.mem_we) begin
            mem[bus.mem_addr]    <= bus.mem_wdata;
            wr_map[bus.mem_addr] <= 1'b1;
        end
        if (bus.mem_en && !bus.mem_we) begin
            p1 <= wr_map[bus.mem_addr] ? mem[bus.mem_addr]
                                       : init_word(bus.mem_addr);
        end else begin
            p1 <= 32'h0;
        end
        p2 <= p1;
    end

    assign bus.mem_rdata = p2;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] grants;
    logic [7:0] exp_g;
    int         ngr;
    int         cyc;
    logic       seen;

    initial begin
        rst         = 1'b1;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        grants      = '0;
        repeat (2) step();

        chk("rst_if_ack", 32'(bus.if_ack), 32'd0);
        chk("rst_d_ack", 32'(bus.d_ack), 32'd0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        rst = 1'b0;
        step();

        // Single IF read.
        bus.if_req  = 1'b1;
        bus.if_addr = 10'h004;
        step();
        chk("if1_ack", 32'(bus.if_ack), 32'd1);
        chk("if1_mem_en", 32'(bus.mem_en), 32'd1);
        chk("if1_mem_addr", 32'(bus.mem_addr), 32'h004);
        chk("if1_mem_we", 32'(bus.mem_we), 32'd0);
        chk("if1_busy", 32'(bus.busy), 32'd1);
        bus.if_req = 1'b0;
        step();
        step();
        chk("if1_c3_rvalid", 32'(bus.if_rvalid), 32'd0);
        step();
        chk("if1_rvalid", 32'(bus.if_rvalid), 32'd1);
        chk("if1_rdata", bus.if_rdata, 32'hDEADBEEF);
        step();
        chk("if1_c5_busy", 32'(bus.busy), 32'd0);
        chk("if1_c5_rvalid", 32'(bus.if_rvalid), 32'd0);

        // Data store.
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 10'h3FF;
        bus.d_wdata = 32'h12345678;
        step();
        chk("st_d_ack", 32'(bus.d_ack), 32'd1);
        chk("st_mem_en", 32'(bus.mem_en), 32'd1);
        chk("st_mem_we", 32'(bus.mem_we), 32'd1);
        chk("st_mem_addr", 32'(bus.mem_addr), 32'h3FF);
        chk("st_mem_wdata", bus.mem_wdata, 32'h12345678);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        step();
        chk("st_c2_busy", 32'(bus.busy), 32'd0);
        chk("st_c2_mem_we", 32'(bus.mem_we), 32'd0);
        seen = bus.d_rvalid;
        repeat (3) begin
            step();
            seen = seen | bus.d_rvalid;
        end
        chk("st_no_rvalid", 32'(seen), 32'd0);
        chk("st_if_rdata_kept", bus.if_rdata, 32'hDEADBEEF);

        // Data load of the stored word.
        bus.d_req  = 1'b1;
        bus.d_addr = 10'h3FF;
        step();
        chk("ld_d_ack", 32'(bus.d_ack), 32'd1);
        bus.d_req = 1'b0;
        repeat (3) step();
        chk("ld_d_rvalid", 32'(bus.d_rvalid), 32'd1);
        chk("ld_d_rdata", bus.d_rdata, 32'h12345678);
        chk("ld_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        step();

        // Back-to-back IF reads.
        bus.if_req  = 1'b1;
        bus.if_addr = 10'h004;
        step();
        chk("b2b_ack1", 32'(bus.if_ack), 32'd1);
        bus.if_req = 1'b0;
        repeat (3) step();
        chk("b2b_rvalid1", 32'(bus.if_rvalid), 32'd1);
        bus.if_req  = 1'b1;
        bus.if_addr = 10'h005;
        step();
        chk("b2b_ack2", 32'(bus.if_ack), 32'd1);
        chk("b2b_addr2", 32'(bus.mem_addr), 32'h005);
        bus.if_req = 1'b0;
        repeat (3) step();
        chk("b2b_rvalid2", 32'(bus.if_rvalid), 32'd1);
        chk("b2b_rdata2", bus.if_rdata, 32'hCAFEF00D);
        step();

        // Both requesters held: record eight grants.
`ifdef MIPS32_ARB_STARVE_GUARD_EN
        exp_g = 8'b1000_1000;
`else
        exp_g = 8'b0000_0000;
`endif
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 10'h010;
        bus.if_req  = 1'b1;
        bus.if_addr = 10'h020;
        ngr = 0;
        cyc = 0;
        while (ngr < 8 && cyc < 60) begin
            step();
            cyc++;
            if (bus.d_ack || bus.if_ack) begin
                grants[ngr] = bus.if_ack;
                ngr++;
            end
        end
        chk("both_grant_count", 32'(ngr), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("both_grant%0d_is_if", k), 32'(grants[k]),
                32'(exp_g[k]));
        end
        bus.d_req  = 1'b0;
        bus.if_req = 1'b0;
        repeat (4) step();
        chk("both_idle", 32'(bus.busy), 32'd0);

        // Data wins, then drops; IF wins at the next arbitration edge.
        bus.d_req  = 1'b1;
        bus.if_req = 1'b1;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!(bus.d_ack || bus.if_ack) && cyc < 10);
        chk("drop_first_d_ack", 32'(bus.d_ack), 32'd1);
        bus.d_req = 1'b0;
        repeat (3) step();
        chk("drop_c4_if_ack", 32'(bus.if_ack), 32'd0);
        step();
        chk("drop_c5_if_ack", 32'(bus.if_ack), 32'd1);
        chk("drop_c5_addr", 32'(bus.mem_addr), 32'h020);
        bus.if_req = 1'b0;
        repeat (3) step();
        chk("drop_rvalid", 32'(bus.if_rvalid), 32'd1);
        chk("drop_rdata", bus.if_rdata, 32'hA5A50020);
        step();

        // Reset during a store ISSUE: strobes drop without a clock edge.
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 10'h100;
        bus.d_wdata = 32'h000055AA;
        step();
        chk("rsti_mem_en_pre", 32'(bus.mem_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rsti_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rsti_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rsti_busy", 32'(bus.busy), 32'd0);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Reset during WAIT: the read is dropped.
        bus.if_req  = 1'b1;
        bus.if_addr = 10'h004;
        step();
        chk("rstw_ack", 32'(bus.if_ack), 32'd1);
        bus.if_req = 1'b0;
        step();
        chk("rstw_busy_pre", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstw_busy", 32'(bus.busy), 32'd0);
        chk("rstw_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rstw_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        step();
        rst  = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            step();
            seen = seen | bus.if_rvalid;
        end
        chk("rstw_no_rvalid", 32'(seen), 32'd0);

        bus.if_req  = 1'b1;
        bus.if_addr = 10'h005;
        step();
        chk("post_rst_ack", 32'(bus.if_ack), 32'd1);
        bus.if_req = 1'b0;
        repeat (3) step();
        chk("post_rst_rvalid", 32'(bus.if_rvalid), 32'd1);
        chk("post_rst_rdata", bus.if_rdata, 32'hCAFEF00D);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mips32_mem_arbiter.md
Name: mips32_mem_arbiter

Overview:
- Arbitrates the single-port 1024x32 unified memory between the instruction-fetch requester (IF) and the data requester (MEM stage: LW/SW).
- One transaction outstanding at a time. Fixed-latency reads, single-cycle writes.
- Data port has priority. An optional starvation guard bounds how long IF can be locked out.
- Sits between the pipeline stages and the memory macro. Stage stall logic is driven from its ack/rvalid pulses.

Parameters:
- AW, 10, memory word-address width
- DW, 32, data width
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata (legal range 1..15)
- STARVE_MAX, 3, consecutive IF losses before IF is forced to win (used only with the optional feature)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous active-high reset
- if_req  in  1  IF read request; held until if_ack
- if_addr  in  AW  IF word address
- if_ack  out  1  one-cycle pulse: IF request issued to memory
- if_rdata  out  DW  IF read data
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data word address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle pulse: data request issued
- d_rdata  out  DW  load data
- d_rvalid  out  1  one-cycle pulse: d_rdata valid (loads only)
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the mem_en cycle
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; wait counter 0; starvation counter 0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Arbitration is sampled at the rising edge while in IDLE or RESP:
  - d_req alone: data wins.
  - if_req alone: IF wins.
  - Both requests: data wins, except when the optional guard forces IF.
  - Neither request: go to IDLE.
- ISSUE (1 cycle):
  - Winner's ack = 1.
  - mem_en = 1.
  - mem_addr = winner address.
  - mem_we = d_we for a data winner, else 0.
  - mem_wdata = d_wdata.
  - Address and data are latched at the arbitration edge.
- After ISSUE:
  - Write: go to IDLE. No rvalid is produced.
  - Read: go to WAIT with counter = MEM_LAT.
- WAIT: counter decrements every cycle. On the edge ending the cycle with counter == 1, capture mem_rdata into the winner's rdata register and go to RESP.
- RESP (1 cycle): winner's rvalid = 1, rdata stable. Arbitration happens at the end of RESP, so back-to-back reads issue with no idle cycle.
- Read latency: rvalid is asserted MEM_LAT+1 cycles after the ack cycle. With MEM_LAT = 2: ack in c1, rvalid in c4.
- Write throughput: 1 write per 2 cycles (ISSUE, IDLE).
- rdata registers hold their last value until the next capture. They are not cleared by a write.
- Requesters must drop req (or present a new request) in the cycle after ack. req is ignored outside IDLE/RESP.
- A req asserted in ISSUE or WAIT waits; it is not lost.
- Reset mid-operation:
  - Immediate return to IDLE.
  - Any pending read is dropped; no rvalid is produced.
  - Counters are cleared.
  - mem_en/mem_we drop asynchronously.
- mem_we is never 1 without mem_en.

Optional Feature:
- Macro: MIPS32_ARB_STARVE_GUARD_EN.
- Defined:
  - A starvation counter (width clog2(STARVE_MAX+1)) increments at each arbitration where both requests are present and data wins.
  - When the counter == STARVE_MAX and both requests are present, IF wins.
  - The counter clears whenever IF wins, and saturates at STARVE_MAX.
- Undefined: strict data priority; no counter logic is present; IF can starve indefinitely.

Test Plan:
- Single IF read, MEM_LAT=2: if_req=1, if_addr=0x004, mem returns 0xDEADBEEF -> if_ack in c1 with mem_en=1, mem_addr=0x004, mem_we=0; if_rvalid=1, if_rdata=0xDEADBEEF in c4; busy=0 in c5.
- Data store: d_req=1, d_we=1, d_addr=0x3FF, d_wdata=0x12345678 -> d_ack=1, mem_en=1, mem_we=1 in c1; no d_rvalid; IDLE in c2.
- Simultaneous requests, guard undefined: both req held continuously, data issues 5 loads -> IF gets no ack until d_req drops, then if_ack on the next arbitration edge.
- Simultaneous requests, guard defined, STARVE_MAX=3: both held continuously -> grant order D, D, D, IF, D, D, D, IF.
- Back-to-back IF reads: if_req re-asserted in RESP with addr 0x005 -> second if_ack in the cycle immediately after the first if_rvalid.
- Async reset in WAIT: rst pulsed mid-read -> mem_en, busy, if_rvalid = 0 immediately; no if_rvalid ever for that read; a new if_req after reset completes normally.
